// File: rtl/multiplier_pkg.sv
// Shared constants and state encoding for the shift-and-add multiply-accumulate unit.
// The divider imports WA/WB from here so both blocks agree on operand widths.
package mul_pkg;

  localparam int unsigned WA = 8;
  localparam int unsigned WB = 7;
  localparam int unsigned WP = WA + WB;
  localparam int unsigned CW = $clog2(WB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_if.sv
// Start-pulse request/result bundle shared by the multiplier and its requester.
interface multiplier_if;
  import mul_pkg::*;

  logic          start;
  logic [WA-1:0] multiplicandin;
  logic [WB-1:0] multiplierin;
  logic [WB-1:0] addendin;
  logic [WP-1:0] product;
  logic          valid;

  modport master (
    output start, multiplicandin, multiplierin, addendin,
    input  product, valid
  );

  modport slave (
    input  start, multiplicandin, multiplierin, addendin,
    output product, valid
  );

endinterface

// File: rtl/multiplier.sv
// Sequential multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per cycle, fixed latency, registered outputs.
module multiplier
  import mul_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  multiplier_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  state_t        state, state_next;
  logic [WP-1:0] acc, acc_next;
  logic [WP-1:0] mcand, mcand_next;
  logic [WB-1:0] mplier, mplier_next;
  logic [CW-1:0] count, count_next;
  logic [WP-1:0] product, product_next;
  logic          valid, valid_next;
  logic [WP-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      count   <= count_next;
      product <= product_next;
      valid   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    mcand_next   = mcand;
    mplier_next  = mplier;
    count_next   = count;
    product_next = product;
    valid_next   = valid;
    sum          = mplier[0] ? (acc + mcand) : acc;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_LOAD;
          valid_next = 1'b0;
        end
      end

      // start is deliberately not looked at here: operands are always taken
      ST_LOAD: begin
        acc_next    = WP'(bus.addendin);
        mcand_next  = WP'(bus.multiplicandin);
        mplier_next = bus.multiplierin;
        count_next  = '0;
        state_next  = ST_RUN;
      end

      ST_RUN: begin
        if (bus.start) begin
          state_next = ST_LOAD;
          valid_next = 1'b0;
        end else begin
          acc_next    = sum;
          mcand_next  = mcand << 1;
          mplier_next = mplier >> 1;
          count_next  = count + 1'b1;
          if (count == LAST) begin
            product_next = sum;
            valid_next   = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.product = product;
  assign bus.valid   = valid;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the multiply-accumulate unit with a queue of expected products.
module tb_multiplier
  import mul_pkg::*;
;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   sb[$];

  multiplier_if bus ();

  multiplier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start pulse at E0, operands presented for E1, then scrambled so later
  // edges cannot pick them up.
  task automatic issue(input int a, input int b, input int c);
    logic [31:0] av, bv, cv;
    av = a; bv = b; cv = c;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("valid_low_E0", bus.valid, 0);
    @(negedge clk);
    bus.start          = 1'b0;
    bus.multiplicandin = av[WA-1:0];
    bus.multiplierin   = bv[WB-1:0];
    bus.addendin       = cv[WB-1:0];
    @(posedge clk); #1;
    chk("valid_low_E1", bus.valid, 0);
    @(negedge clk);
    bus.multiplicandin = WA'($urandom);
    bus.multiplierin   = WB'($urandom);
    bus.addendin       = WB'($urandom);
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("valid_stays_low", bus.valid, 0);
    end
  endtask

  // Edges counted after E1; valid must first rise at E8, i.e. 7 edges later.
  task automatic wait_result(input int exp_edges);
    int n;
    bit got;
    int exp;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.valid === 1'b1) got = 1'b1;
    end
    chk("valid_seen", 32'(got), 1);
    chk("latency", n, exp_edges);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      exp = sb.pop_front();
      chk("product", bus.product, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dividend, divisor, q, r;
    bus.start = 1'b0;
    bus.multiplicandin = '0;
    bus.multiplierin = '0;
    bus.addendin = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", bus.product, 0);
    chk("reset_valid", bus.valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // basic + hold
    issue(13, 5, 3);
    sb.push_back(68);
    wait_result(7);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.valid, 1);
      chk("hold_product", bus.product, 68);
    end

    // max operands
    issue(255, 127, 127);
    sb.push_back(32512);
    wait_result(7);
    chk("max_bit14", 32'(bus.product[WP-1]), 1);

    // zero operands
    issue(200, 0, 9);
    sb.push_back(9);
    wait_result(7);
    issue(0, 100, 0);
    sb.push_back(0);
    wait_result(7);
    chk("zero_valid", bus.valid, 1);

    // restart while running: second start lands on E4
    issue(50, 3, 0);
    expect_idle(2);
    issue(10, 10, 1);
    sb.push_back(101);
    wait_result(7);

    // reset mid-operation at E5
    issue(20, 20, 5);
    expect_idle(3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_product", bus.product, 0);
    chk("midreset_valid", bus.valid, 0);
    @(negedge clk);
    reset = 1'b0;
    expect_idle(6);
    issue(7, 9, 4);
    sb.push_back(67);
    wait_result(7);

    // start coincident with reset is lost
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_valid", bus.valid, 0);
    chk("rst_start_product", bus.product, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    expect_idle(10);

    // divider round trip
    for (int k = 0; k < 40; k++) begin
      dividend = int'($urandom_range(0, 255));
      divisor  = int'($urandom_range(1, 127));
      q = dividend / divisor;
      r = dividend % divisor;
      issue(q, divisor, r);
      sb.push_back(dividend);
      wait_result(7);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential shift-and-add multiply-accumulate unit. Computes product = multiplicand * multiplier + addend.
- It is the inverse of the divider: it rebuilds dividend = quotient * divisor + remainder.
- Uses the divider's one-cycle start-pulse protocol: operands are sampled the cycle after start, and the result is held with valid after a fixed latency.
- Sits beside the divider. It is used for self-checking (round-trip the divider result) and for general product generation.

Parameters:
- WA, 8, multiplicand width (matches quotient/dividend width)
- WB, 7, multiplier and addend width (matches divisor/remainder width)
- WP, WA+WB, product width (15). Worst case 255*127+127 = 32512 fits, so no overflow is possible.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request pulse
- multiplicandin  input  WA  operand A (e.g. quotient); sampled the cycle after start
- multiplierin  input  WB  operand B (e.g. divisor); sampled the cycle after start
- addendin  input  WB  addend (e.g. remainder); sampled the cycle after start
- product  output  WP  registered result
- valid  output  1  high while product holds a completed result

Behaviour:
- Reset: synchronous, active-high, wins over all other inputs. It forces state=IDLE, product=0, valid=0, and clears all internal registers. Reset mid-operation abandons the computation, and no valid is ever produced for it.
- States:
  - IDLE, LOAD, RUN. Two-bit encoding from the package.
- Edge numbering: E0 = the rising edge where start=1 is sampled.
- E0 (start seen, any state):
  - state goes to LOAD.
  - valid goes to 0; product is unchanged.
- E1 (LOAD):
  - Latch acc = zero-extended addendin, mcand = zero-extended multiplicandin (WP bits), mplier = multiplierin.
  - Set count = 0; state goes to RUN.
  - start is ignored at this edge. Operands are sampled regardless of start.
- E2..E(WB+1) (RUN, one multiplier bit per cycle, LSB first):
  - If mplier[0] = 1, acc = acc + mcand, done in WP-bit arithmetic with no carry-out.
  - Then mcand shifts left by 1, mplier shifts right by 1, and count increments.
- Final iteration, count = WB-1, edge E8 for WB=7:
  - product = the final acc value, including this cycle's add.
  - valid = 1; state goes to IDLE.
- Latency: result visible after E8, which is 7 cycles after the operand-sampling edge (8 after start). This is well inside the 17-cycle check window used for the divider.
- Hold: product and valid stay stable in IDLE indefinitely until the next start or reset.
- start while in RUN: abort and restart. At that edge state goes to LOAD and valid stays 0. The old computation never produces valid.
- start asserted on the same edge as reset: reset wins, and start is lost.
- start held high for several cycles: each sampled start restarts. Operands are taken the cycle after the last start.
- Zero operands: multiplier = 0 or multiplicand = 0 gives product = addend. The latency is still fixed; there is no early termination.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package mul_pkg:
  - WA, WB, WP constants.
  - State encoding constants ST_IDLE = 0, ST_LOAD = 1, ST_RUN = 2.
  - Counter width = clog2(WB).
- Single module. No sub-module is needed; the datapath is one WP-bit adder plus two shift registers and a counter.
- The divider can import the same WA/WB constants from mul_pkg.

Test Plan:
- Basic: start pulse, next cycle multiplicandin=13, multiplierin=5, addendin=3 -> at E8 product=68, valid=1. valid=0 at E1..E7, and the values hold until the next start.
- Max values: 255, 127, 127 -> product=32512. No wrap; bit 14 = 1.
- Zero multiplier: 200, 0, 9 -> product=9 at exactly E8. Then 0, 100, 0 -> product=0 with valid=1.
- Restart: start at E0, then start again at E4 while in RUN with new operands 10, 10, 1 -> the first job never raises valid. product=101 appears 8 edges after the second start.
- Reset mid-op: reset high at E5 for one cycle -> product=0 and valid=0 from E5. Nothing appears at E8. A subsequent start works normally.
- Divider round-trip: 40 random pairs; feed the divider's quotient, divisor and remainder -> product equals the original dividend for every pair.
